// File: rtl/bsn.sv
// -----------------------------------------------------------------------------
// bsn -- pipelined bitonic sorting network
//
// Sorts N_INPUTS unsigned keys of DATA_WIDTH bits. The network has
// L = log2(N_INPUTS) merge phases and S = L*(L+1)/2 compare-exchange stages.
// Each stage ends in a register, so latency is S enabled clock edges and one
// vector can be accepted on every enabled cycle.
//
// Configuration macro:
//   BSN_DESCEND_EN  defined   -> lane 0 holds the maximum key
//                   undefined -> lane 0 holds the minimum key (ascending)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset; clears every stage to 0
//   en        in   pipeline advance; when low every stage holds its value
//   data_in   in   packed keys, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_out  out  packed sorted keys, same lane packing, straight from the
//                  last stage register
// -----------------------------------------------------------------------------
module bsn #(
    parameter int DATA_WIDTH = 32,
    parameter int N_INPUTS   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [DATA_WIDTH*N_INPUTS-1:0]   data_in,
    output logic [DATA_WIDTH*N_INPUTS-1:0]   data_out
);

    localparam int L  = $clog2(N_INPUTS);
    localparam int S  = (L * (L + 1)) / 2;
    localparam int VW = DATA_WIDTH * N_INPUTS;

`ifdef BSN_DESCEND_EN
    localparam logic DESCEND = 1'b1;
`else
    localparam logic DESCEND = 1'b0;
`endif

    // Reject lane counts the bitonic structure cannot handle.
    if ((N_INPUTS < 2) || ((N_INPUTS & (N_INPUTS - 1)) != 0)) begin : g_bad_n
        $error("bsn: N_INPUTS must be a power of two and at least 2");
    end

    // One compare-exchange stage of phase k, step distance 2^j.
    // Lane bit (k+1) picks the direction; in the last phase that bit is zero
    // for every lane, so the whole final merge runs in one direction.
    // Flipping every direction mirrors the network and reverses the output.
    // Equal keys are left in place.
    function automatic logic [VW-1:0] cmp_exchange(
        input logic [VW-1:0] v,
        input int            k,
        input int            j
    );
        logic [VW-1:0]         res;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  up;
        int                    p;
        res = v;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (((i >> j) & 32'd1) == 32'd0) begin
                p  = i | (32'sd1 << j);
                a  = v[i*DATA_WIDTH +: DATA_WIDTH];
                b  = v[p*DATA_WIDTH +: DATA_WIDTH];
                up = ((((i >> (k + 1)) & 32'd1) == 32'd0) ? 1'b1 : 1'b0) ^ DESCEND;
                if ((up && (a > b)) || (!up && (a < b))) begin
                    res[i*DATA_WIDTH +: DATA_WIDTH] = b;
                    res[p*DATA_WIDTH +: DATA_WIDTH] = a;
                end else begin
                    res[i*DATA_WIDTH +: DATA_WIDTH] = a;
                    res[p*DATA_WIDTH +: DATA_WIDTH] = b;
                end
            end else begin
                p = i;
            end
        end
        return res;
    endfunction

    logic [VW-1:0] r_stage    [S];
    logic [VW-1:0] w_stage_in [S];
    logic [VW-1:0] w_next     [S];

    // Stage 0 samples data_in directly; later stages take the previous register.
    assign w_stage_in[0] = data_in;
    for (genvar s = 1; s < S; s++) begin : g_chain
        assign w_stage_in[s] = r_stage[s-1];
    end

    // Stage s corresponds to phase k, step j, enumerated k = 0..L-1 and
    // j = k down to 0 within each phase.
    for (genvar k = 0; k < L; k++) begin : g_phase
        for (genvar m = 0; m <= k; m++) begin : g_step
            localparam int J  = k - m;
            localparam int SI = ((k * (k + 1)) / 2) + m;
            assign w_next[SI] = cmp_exchange(w_stage_in[SI], k, J);
        end
    end

    // Stage registers: async clear, all stages advance together on en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < S; s++) begin
                r_stage[s] <= '0;
            end
        end else if (en) begin
            for (int s = 0; s < S; s++) begin
                r_stage[s] <= w_next[s];
            end
        end else begin
            for (int s = 0; s < S; s++) begin
                r_stage[s] <= r_stage[s];
            end
        end
    end

    assign data_out = r_stage[S-1];

endmodule

// File: tb/tb_bsn.sv
// -----------------------------------------------------------------------------
// tb_bsn -- self-checking bench for bsn (N_INPUTS = 8, DATA_WIDTH = 32).
// A reference model sorts each accepted vector with plain insertion sort and
// delays it by S accepted edges; data_out is compared with it every cycle.
// Directed vectors with literal expectations pin both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_bsn;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int S  = 6;
    localparam int VW = W * N;

    logic          clk;
    logic          rst;
    logic          en;
    logic [VW-1:0] data_in;
    logic [VW-1:0] data_out;

    int n_checks;
    int n_fail;
    bit chk_on;

    logic [VW-1:0] mdl [S];

    bsn #(.DATA_WIDTH(W), .N_INPUTS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sorted version of a vector in the configured output order.
    function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
        logic [W-1:0]  a [N];
        logic [W-1:0]  t;
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > a[j]) begin
                    t = a[j-1]; a[j-1] = a[j]; a[j] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
`ifdef BSN_DESCEND_EN
            r[i*W +: W] = a[N-1-i];
`else
            r[i*W +: W] = a[i];
`endif
        end
        return r;
    endfunction

    // Literal expectations are written ascending; mirror them when descending.
    function automatic logic [VW-1:0] orient(input logic [VW-1:0] asc);
`ifdef BSN_DESCEND_EN
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = asc[(N-1-i)*W +: W];
        return r;
`else
        return asc;
`endif
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) r[i*W +: W] = W'($urandom_range(0, 7));
            else                           r[i*W +: W] = $urandom;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: a delay line of already-sorted vectors.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < S; s++) mdl[s] <= '0;
        end else if (en) begin
            for (int s = S - 1; s > 0; s--) mdl[s] <= mdl[s-1];
            mdl[0] <= sort_vec(data_in);
        end
    end

    // Continuous comparison, well away from the active edge.
    always @(posedge clk) begin
        #3;
        if (chk_on) check("stream", data_out, mdl[S-1]);
    end

    task automatic directed(input string name, input logic [VW-1:0] vin, input logic [VW-1:0] asc);
        @(negedge clk);
        en      = 1'b1;
        data_in = vin;
        @(negedge clk);
        data_in = rand_vec();
        repeat (S - 1) @(posedge clk);
        #3;
        check(name, data_out, orient(asc));
        check({"model_", name}, mdl[S-1], orient(asc));
    endtask

    initial begin
        logic [VW-1:0] v;
        n_checks = 0;
        n_fail   = 0;
        chk_on   = 1'b0;
        rst      = 1'b0;
        en       = 1'b0;
        data_in  = '0;

        repeat (2) @(negedge clk);
        check("reset_state", data_out, {VW{1'b0}});
        rst    = 1'b1;
        chk_on = 1'b1;

        directed("reverse_input",
                 {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                 {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        directed("forward_input",
                 {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                 {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        directed("dups_extremes",
                 {32'd5, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd3, 32'd3, 32'h8000_0000, 32'd1},
                 {32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'd5, 32'd3, 32'd3, 32'd1, 32'd0});

        // Streaming with a fixed 3-cycle stall in the middle.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            en      = (c >= 20 && c < 23) ? 1'b0 : 1'b1;
            data_in = rand_vec();
        end

        // Random enable pattern.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            data_in = rand_vec();
        end

        // Reset with three vectors in flight.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            en      = 1'b1;
            data_in = rand_vec();
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_mid_immediate", data_out, {VW{1'b0}});
        @(negedge clk);
        rst        = 1'b1;
        v          = rand_vec();
        v[W-1:0]   = 32'hDEAD_BEEF;
        data_in    = v;
        @(negedge clk);
        data_in = '0;
        repeat (4) @(posedge clk);
        #3;
        check("post_reset_still_zero", data_out, {VW{1'b0}});
        @(posedge clk);
        #3;
        check("post_reset_first_vec", data_out, sort_vec(v));

        repeat (10) begin
            @(negedge clk);
            data_in = rand_vec();
        end
        @(negedge clk);
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
